// File: rtl/nrisc_data_mem_ctrl_if.sv
// Bus bundle between the CPU data port, the data-memory controller and the SRAM.
// The controller takes the slave view; the CPU/SRAM side takes the master view.
interface nrisc_data_mem_ctrl_if #(
    parameter int TAM    = 16,
    parameter int ADDR_W = 10
);
    logic              CORE_DATA_load;
    logic              CORE_DATA_write;
    logic [TAM-1:0]    CORE_DATA_ADDR;
    logic [TAM-1:0]    DATA_IN;
    logic [TAM-1:0]    DATA_Out;
    logic              mem_busy;
    logic              mem_ack;
    logic              mem_err;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [TAM-1:0]    mem_wdata;
    logic [TAM-1:0]    mem_rdata;

    modport slave (
        input  CORE_DATA_load, CORE_DATA_write, CORE_DATA_ADDR, DATA_IN, mem_rdata,
        output DATA_Out, mem_busy, mem_ack, mem_err, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output CORE_DATA_load, CORE_DATA_write, CORE_DATA_ADDR, DATA_IN, mem_rdata,
        input  DATA_Out, mem_busy, mem_ack, mem_err, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nrisc_data_mem_ctrl.sv
// Data-memory controller: runs CPU load/write requests on a synchronous SRAM
// with a fixed number of wait states, flagging conflicting and out-of-range requests.
module nrisc_data_mem_ctrl #(
    parameter int TAM      = 16,
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    nrisc_data_mem_ctrl_if.slave   bus
);
    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TAM-1:0]    wdata_q;
    logic [TAM-1:0]    rdata_q;
    logic              err_q;
    logic              req;
    logic              out_of_range;

    assign req          = bus.CORE_DATA_load | bus.CORE_DATA_write;
    // Any address bit above the SRAM window makes the request out of range.
    assign out_of_range = (bus.CORE_DATA_ADDR >> ADDR_W) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_busy  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.DATA_Out  = rdata_q;
        bus.mem_err   = err_q;
        case (state)
            IDLE: begin
                if (req) state_nxt = out_of_range ? DONE : ACCESS;
            end
            ACCESS: begin
                bus.mem_cs   = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_busy = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                bus.mem_ack = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both requests are raised together.
                        we_q    <= bus.CORE_DATA_write;
                        addr_q  <= bus.CORE_DATA_ADDR[ADDR_W-1:0];
                        wdata_q <= bus.DATA_IN;
                        cnt     <= CNT_W'(WAIT_CYC);
                        if ((bus.CORE_DATA_load & bus.CORE_DATA_write) | out_of_range)
                            err_q <= 1'b1;
                        if (out_of_range & ~bus.CORE_DATA_write)
                            rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt != '0)  cnt     <= cnt - 1'b1;
                    else if (!we_q) rdata_q <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nrisc_data_mem_ctrl.sv
// Directed bench for nrisc_data_mem_ctrl: one instance with two wait states backed
// by an SRAM model, and one with zero wait states for back-to-back timing.
module tb_nrisc_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nrisc_data_mem_ctrl_if #(.TAM(16), .ADDR_W(10)) bus_a ();
    nrisc_data_mem_ctrl_if #(.TAM(16), .ADDR_W(10)) bus_b ();

    nrisc_data_mem_ctrl #(.TAM(16), .ADDR_W(10), .WAIT_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    nrisc_data_mem_ctrl #(.TAM(16), .ADDR_W(10), .WAIT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [15:0] sram [0:1023];
    always @(posedge clk)
        if (bus_a.mem_cs && bus_a.mem_we) sram[bus_a.mem_addr] <= bus_a.mem_wdata;
    assign bus_a.mem_rdata = sram[bus_a.mem_addr];
    assign bus_b.mem_rdata = 16'hC000 | {6'd0, bus_b.mem_addr};

    task automatic drive_a(input logic ld, input logic wr, input logic [15:0] ad, input logic [15:0] d);
        bus_a.CORE_DATA_load  = ld;
        bus_a.CORE_DATA_write = wr;
        bus_a.CORE_DATA_ADDR  = ad;
        bus_a.DATA_IN         = d;
    endtask

    task automatic test_reset_values;
        @(negedge clk);
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl_a: got %b expected 00000",
                {bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err});
        end
        n_tests++;
        if ({bus_a.DATA_Out, bus_a.mem_addr, bus_a.mem_wdata} !== 42'd0) begin
            n_fail++; $display("FAIL reset_data_a: got %h expected 0",
                {bus_a.DATA_Out, bus_a.mem_addr, bus_a.mem_wdata});
        end
        n_tests++;
        if ({bus_b.mem_cs, bus_b.mem_busy, bus_b.mem_ack, bus_b.mem_err, bus_b.DATA_Out} !== 20'd0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 0",
                {bus_b.mem_cs, bus_b.mem_busy, bus_b.mem_ack, bus_b.mem_err, bus_b.DATA_Out});
        end
        rst = 1'b0;
    endtask

    task automatic test_write;
        @(negedge clk);
        drive_a(1'b0, 1'b1, 16'h0012, 16'hBEEF);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
            n_tests++;
            if ({bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack} !== 4'b1110) begin
                n_fail++; $display("FAIL write_ctrl cyc%0d: got %b expected 1110", i,
                    {bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack});
            end
            n_tests++;
            if (bus_a.mem_addr !== 10'h012 || bus_a.mem_wdata !== 16'hBEEF) begin
                n_fail++; $display("FAIL write_bus cyc%0d: got %h/%h expected 012/beef", i,
                    bus_a.mem_addr, bus_a.mem_wdata);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack} !== 3'b001 || bus_a.DATA_Out !== 16'h0000) begin
            n_fail++; $display("FAIL write_ack: got %b data %h expected 001 data 0000",
                {bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack}, bus_a.DATA_Out);
        end
        n_tests++;
        if (sram[10'h012] !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_sram: got %h expected beef", sram[10'h012]);
        end
    endtask

    task automatic test_readback;
        @(negedge clk);
        drive_a(1'b1, 1'b0, 16'h0012, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
            n_tests++;
            if ({bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack} !== 4'b1010 ||
                bus_a.DATA_Out !== 16'h0000) begin
                n_fail++; $display("FAIL read_ctrl cyc%0d: got %b data %h expected 1010 data 0000", i,
                    {bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack}, bus_a.DATA_Out);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus_a.mem_ack !== 1'b1 || bus_a.mem_busy !== 1'b0 || bus_a.DATA_Out !== 16'hBEEF) begin
            n_fail++; $display("FAIL read_ack: got ack %b busy %b data %h expected 1 0 beef",
                bus_a.mem_ack, bus_a.mem_busy, bus_a.DATA_Out);
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        drive_a(1'b1, 1'b1, 16'h0005, 16'h00A5);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_we} !== 2'b11 || bus_a.mem_addr !== 10'h005 || bus_a.mem_err !== 1'b1) begin
            n_fail++; $display("FAIL simul_access: got cs/we %b addr %h err %b expected 11 005 1",
                {bus_a.mem_cs, bus_a.mem_we}, bus_a.mem_addr, bus_a.mem_err);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_a.mem_ack !== 1'b1 || sram[10'h005] !== 16'h00A5 || bus_a.DATA_Out !== 16'hBEEF) begin
            n_fail++; $display("FAIL simul_done: got ack %b sram %h data %h expected 1 00a5 beef",
                bus_a.mem_ack, sram[10'h005], bus_a.DATA_Out);
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        drive_a(1'b0, 1'b1, 16'h0040, 16'h1234);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        n_tests++;
        if (bus_a.mem_cs !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_cs: got %b expected 1", bus_a.mem_cs);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err} !== 5'b0 ||
            {bus_a.DATA_Out, bus_a.mem_addr, bus_a.mem_wdata} !== 42'd0) begin
            n_fail++; $display("FAIL rst_async: got %b %h expected 00000 0",
                {bus_a.mem_cs, bus_a.mem_we, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err},
                {bus_a.DATA_Out, bus_a.mem_addr, bus_a.mem_wdata});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err} !== 4'b0) begin
            n_fail++; $display("FAIL rst_idle: got %b expected 0000",
                {bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err});
        end
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        drive_a(1'b1, 1'b0, 16'h0012, 16'h0000);
        repeat (4) @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_tests++;
        if (bus_a.DATA_Out !== 16'hBEEF) begin
            n_fail++; $display("FAIL oor_setup: got %h expected beef", bus_a.DATA_Out);
        end
        @(negedge clk);
        drive_a(1'b1, 1'b0, 16'h0400, 16'h0000);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_tests++;
        if ({bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err} !== 4'b0011 ||
            bus_a.DATA_Out !== 16'h0000) begin
            n_fail++; $display("FAIL oor_ack: got %b data %h expected 0011 data 0000",
                {bus_a.mem_cs, bus_a.mem_busy, bus_a.mem_ack, bus_a.mem_err}, bus_a.DATA_Out);
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (bus_a.mem_err !== 1'b1 || bus_a.mem_cs !== 1'b0) begin
                n_fail++; $display("FAIL oor_sticky: got err %b cs %b expected 1 0",
                    bus_a.mem_err, bus_a.mem_cs);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus_b.CORE_DATA_load  = 1'b1;
        bus_b.CORE_DATA_write = 1'b0;
        bus_b.CORE_DATA_ADDR  = 16'h0033;
        bus_b.DATA_IN         = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus_b.mem_cs, bus_b.mem_busy, bus_b.mem_ack} !== {(i % 3 == 0), (i % 3 == 0), (i % 3 == 1)}) begin
                n_fail++; $display("FAIL b2b_ctrl cyc%0d: got %b expected %b", i,
                    {bus_b.mem_cs, bus_b.mem_busy, bus_b.mem_ack},
                    {(i % 3 == 0), (i % 3 == 0), (i % 3 == 1)});
            end
            if (i % 3 == 1) begin
                n_tests++;
                if (bus_b.DATA_Out !== 16'hC033) begin
                    n_fail++; $display("FAIL b2b_data cyc%0d: got %h expected c033", i, bus_b.DATA_Out);
                end
            end
        end
        bus_b.CORE_DATA_load = 1'b0;
    endtask

    initial begin
        drive_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus_b.CORE_DATA_load  = 1'b0;
        bus_b.CORE_DATA_write = 1'b0;
        bus_b.CORE_DATA_ADDR  = 16'h0000;
        bus_b.DATA_IN         = 16'h0000;
        repeat (2) @(negedge clk);
        test_reset_values();
        test_write();
        test_readback();
        test_simultaneous();
        test_reset_mid_access();
        test_out_of_range();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
